// File: rtl/weight_bank_pkg.sv
// Shared sizes and the lane word type for the eight-lane weight bank.
package weight_bank_pkg;
  localparam int LANES   = 8;
  localparam int LANE_W  = 72;
  localparam int RDATA_W = LANES * LANE_W;

  typedef logic [LANE_W-1:0] lane_word_t;
endpackage

// File: rtl/weight_bank_if.sv
// Write/read port bundle of one weight bank; master drives addresses and enables, slave returns rdata.
interface weight_bank_if #(
  parameter int ADDR_WIDTH = 12
);
  import weight_bank_pkg::*;

  logic                  wen   [0:LANES-1];
  lane_word_t            wdata;
  logic [ADDR_WIDTH-1:0] waddr;
  logic                  ren   [0:LANES-1];
  logic [ADDR_WIDTH-1:0] raddr;
  logic [RDATA_W-1:0]    rdata;

  modport master (
    output wen, wdata, waddr, ren, raddr,
    input  rdata
  );

  modport slave (
    input  wen, wdata, waddr, ren, raddr,
    output rdata
  );
endinterface

// File: rtl/weight_lane.sv
// One DEPTH x 72 weight lane: read-first RAM with a 3-register read pipeline (data after edge N+2), no stall path.
// WEIGHT_BANK_ZERO_INIT_EN zero-fills the array at time zero; otherwise contents start undefined.
module weight_lane
  import weight_bank_pkg::*;
#(
  parameter int DEPTH      = 4096,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wen_i,
  input  lane_word_t            wdata_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic                  ren_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output lane_word_t            rdata_o
);

  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);

`ifdef WEIGHT_BANK_ZERO_INIT_EN
  (* ram_style = "ultra" *) lane_word_t mem [DEPTH] = '{default: '0};
`else
  (* ram_style = "ultra" *) lane_word_t mem [DEPTH];
`endif

  logic       wr_ok_d;
  logic       rd_ok_d;
  lane_word_t mem_d;

  logic       en1_q;
  logic       ok1_q;
  lane_word_t ram_q;
  logic       en2_q;
  lane_word_t mem_q;
  lane_word_t out_q;

  always_comb begin
    wr_ok_d = wen_i && ({1'b0, waddr_i} < DEPTH_L);
    rd_ok_d = {1'b0, raddr_i} < DEPTH_L;
    mem_d   = ok1_q ? ram_q : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_ok_d) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  // The array is read at the address-sampling edge, so a same-cycle write is seen by the next read only.
  always_ff @(posedge clk) begin
    if (rst) begin
      en1_q <= 1'b0;
      ok1_q <= 1'b0;
      ram_q <= '0;
      en2_q <= 1'b0;
      mem_q <= '0;
      out_q <= '0;
    end else begin
      en1_q <= ren_i;
      en2_q <= en1_q;
      if (ren_i) begin
        ok1_q <= rd_ok_d;
        if (rd_ok_d) begin
          ram_q <= mem[raddr_i];
        end
      end
      if (en1_q) begin
        mem_q <= mem_d;
      end
      if (en2_q) begin
        out_q <= mem_q;
      end
    end
  end

  assign rdata_o = out_q;

endmodule

// File: rtl/weight_bank.sv
// Eight independent weight lanes sharing write data/address and read address; lane j drives rdata[72j+71:72j].
// Read latency 3 edges per lane, fully pipelined, no backpressure; memory init governed by WEIGHT_BANK_ZERO_INIT_EN.
module weight_bank
  import weight_bank_pkg::*;
#(
  parameter int DEPTH      = 4096,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input logic          clk,
  input logic          rst,
  weight_bank_if.slave bus
);

  lane_word_t [LANES-1:0] lane_rdata;

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    weight_lane #(
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .wen_i   (bus.wen[j]),
      .wdata_i (bus.wdata),
      .waddr_i (bus.waddr),
      .ren_i   (bus.ren[j]),
      .raddr_i (bus.raddr),
      .rdata_o (lane_rdata[j])
    );
  end

  assign bus.rdata = lane_rdata;

endmodule

// File: tb/tb_weight_bank.sv
// Directed bench for weight_bank (DEPTH=4000): expected rdata words queued at read issue, compared every cycle.
module tb_weight_bank;
  import weight_bank_pkg::*;

  localparam int DEPTH = 4000;
  localparam int AW    = 12;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  weight_bank_if #(.ADDR_WIDTH(AW)) bus ();

  weight_bank #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int                 due;
    logic [RDATA_W-1:0] dat;
  } sb_t;

  sb_t                sb [$];
  lane_word_t         mdl  [0:LANES-1][0:4095];
  lane_word_t         last [0:LANES-1];
  logic [RDATA_W-1:0] cur_exp;
  int                 cyc    = 0;
  int                 n_chk  = 0;
  int                 n_fail = 0;

  task automatic check(input string tag, input logic [RDATA_W-1:0] got, input logic [RDATA_W-1:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // One clock edge, then compare rdata against the settled expectation.
  task automatic step();
    sb_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      sb.delete();
      cur_exp = '0;
    end else if (sb.size() != 0 && sb[0].due == cyc) begin
      e       = sb.pop_front();
      cur_exp = e.dat;
    end
    check("rdata", bus.rdata, cur_exp);
  endtask

  task automatic drive(input logic [7:0] wm, input int wa, input lane_word_t wd,
                       input logic [7:0] rm, input int ra, input logic r);
    logic [RDATA_W-1:0] v;
    sb_t                e;
    rst       = r;
    bus.waddr = wa[AW-1:0];
    bus.raddr = ra[AW-1:0];
    bus.wdata = wd;
    for (int j = 0; j < LANES; j++) begin
      bus.wen[j] = wm[j];
      bus.ren[j] = rm[j];
    end
    if (r) begin
      for (int j = 0; j < LANES; j++) last[j] = '0;
    end else begin
      if (rm != 8'h00) begin
        for (int j = 0; j < LANES; j++) begin
          if (rm[j]) last[j] = (ra < DEPTH) ? mdl[j][ra] : '0;
        end
        for (int j = 0; j < LANES; j++) v[j*LANE_W +: LANE_W] = last[j];
        e.due = cyc + 3;
        e.dat = v;
        sb.push_back(e);
      end
      for (int j = 0; j < LANES; j++) begin
        if (wm[j] && wa < DEPTH) mdl[j][wa] = wd;
      end
    end
    step();
  endtask

  task automatic wr(input logic [7:0] wm, input int wa, input lane_word_t wd);
    drive(wm, wa, wd, 8'h00, 0, 1'b0);
  endtask

  task automatic rd(input logic [7:0] rm, input int ra);
    drive(8'h00, 0, '0, rm, ra, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(8'h00, 0, '0, 8'h00, 0, 1'b0);
  endtask

  function automatic lane_word_t pre(input int j, input int a);
    return {8'(j), 16'(a), 48'h0123_4567_89AB};
  endfunction

  initial begin
    int addrs [6];
    addrs = '{0, 1, 5, 9, 3999, 4001};
    cur_exp = '0;
    for (int j = 0; j < LANES; j++) last[j] = '0;
`ifdef WEIGHT_BANK_ZERO_INIT_EN
    for (int j = 0; j < LANES; j++)
      for (int a = 0; a < 4096; a++) mdl[j][a] = '0;
`endif

    // reset with reads requested: nothing may enter the pipeline
    drive(8'h00, 0, '0, 8'hFF, 5, 1'b1);
    drive(8'h00, 0, '0, 8'hFF, 5, 1'b1);
    check("reset_rdata", bus.rdata, '0);

    // per-lane distinct preload, one lane per cycle
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < LANES; j++) wr(8'(1 << j), addrs[i], pre(j, addrs[i]));
    rd(8'hFF, 5);
    idle(3);

    // single-lane write, all-lane read
    wr(8'h08, 5, 72'hA5_0000_0000_0000_0001);
    rd(8'hFF, 5);
    idle(3);

    // distinct values per lane at addr 0, then a back-to-back read stream
    for (int j = 0; j < LANES; j++) wr(8'(1 << j), 0, 72'(j));
    rd(8'hFF, 0);
    rd(8'hFF, 1);
    rd(8'hFF, 0);
    idle(3);

    // same-cycle read/write returns old data; next-cycle read sees new data
    wr(8'hFF, 9, 72'h11);
    drive(8'hFF, 9, 72'h22, 8'hFF, 9, 1'b0);
    rd(8'hFF, 9);
    idle(3);

    // hold with ren low, then refresh lane 2 only
    wr(8'hFF, 1, 72'h33);
    rd(8'hFF, 1);
    idle(8);
    wr(8'hFF, 1, 72'h44);
    rd(8'h04, 1);
    idle(4);

    // reset with two reads in flight; memory survives
    rd(8'hFF, 5);
    rd(8'hFF, 0);
    drive(8'h00, 0, '0, 8'h00, 0, 1'b1);
    check("post_reset_rdata", bus.rdata, '0);
    idle(5);
    rd(8'hFF, 5);
    idle(3);

    // write during reset is dropped
    drive(8'hFF, 9, 72'h55, 8'hFF, 9, 1'b1);
    idle(2);
    rd(8'hFF, 9);
    idle(3);

    // out-of-range addresses and the last valid word
    wr(8'hFF, 4000, 72'h77);
    rd(8'hFF, 4000);
    rd(8'hFF, 4001);
    rd(8'hFF, 3999);
    wr(8'hFF, 3999, 72'h3999);
    rd(8'hFF, 3999);
    rd(8'hFF, 0);
    idle(3);

`ifdef WEIGHT_BANK_ZERO_INIT_EN
    rd(8'hFF, 100);
    idle(3);
`endif

    n_chk++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL sb_drain got=%0d exp=0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
